// File: rtl/port_queue.sv
// CPU port bridge: buffers CPU port writes in a small FIFO toward the device and
// serialises port reads behind any pending writes; a write to address 0 halts the machine.
module port_queue #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] portaddr,
  input  logic [WORD_WIDTH-1:0] portval,
  input  logic                  portset,
  input  logic                  portget,
  output logic [WORD_WIDTH-1:0] portout,
  output logic                  port_busy,
  output logic                  rd_done,
  output logic                  dev_valid,
  input  logic                  dev_ready,
  output logic [WORD_WIDTH-1:0] dev_addr,
  output logic [WORD_WIDTH-1:0] dev_data,
  output logic                  dev_rd_req,
  output logic [WORD_WIDTH-1:0] dev_rd_addr,
  input  logic                  dev_rd_valid,
  input  logic [WORD_WIDTH-1:0] dev_rd_data,
  output logic                  halted,
  output logic                  overflow,
  output logic                  rd_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, REQ} rd_state_t;

  logic [WORD_WIDTH-1:0] mem_addr [DEPTH];
  logic [WORD_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  rd_state_t             state;
  logic [WORD_WIDTH-1:0] rd_addr;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push       = portset && !halted && !full;
  assign dev_valid  = !empty && !halted;
  assign pop        = dev_valid && dev_ready;
  assign count_next = count + CW'(push) - CW'(pop);

  assign dev_addr    = mem_addr[rd_ptr];
  assign dev_data    = mem_data[rd_ptr];
  assign dev_rd_req  = (state == REQ);
  assign dev_rd_addr = rd_addr;
  assign port_busy   = full || (state != IDLE);

  // Queue storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= portaddr;
      mem_data[wr_ptr] <= portval;
    end
  end

  // Queue pointers, occupancy and sticky write-side flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      if (portset && !halted && full) overflow <= 1'b1;
      if (pop && (mem_addr[rd_ptr] == '0)) halted <= 1'b1;
    end
  end

  // Read sequencer: a read waits until every earlier write has left the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_addr <= '0;
      portout <= '0;
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (portget) begin
            rd_addr <= portaddr;
            state   <= (count_next != '0) ? DRAIN : REQ;
          end
        end
        DRAIN: begin
          if (portget) rd_err <= 1'b1;
          if (halted) begin
            state  <= IDLE;
            rd_err <= 1'b1;
          end else if (empty) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (portget) rd_err <= 1'b1;
          if (dev_rd_valid) begin
            portout <= dev_rd_data;
            rd_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/port_queue.md
PORT_QUEUE -- requirements
Module: port_queue

Interface
REQ-001 Parameter WORD_WIDTH, default 16, data/address word width (from parameters.v).
REQ-002 Parameter DEPTH, default 4, write-queue entries, power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 portaddr  input  WORD_WIDTH  CPU port address for current access.
REQ-006 portval  input  WORD_WIDTH  CPU write data.
REQ-007 portset  input  1  one-cycle write strobe from CPU.
REQ-008 portget  input  1  one-cycle read strobe from CPU.
REQ-009 portout  output  WORD_WIDTH  registered read result to CPU.
REQ-010 port_busy  output  1  CPU stall request.
REQ-011 rd_done  output  1  one-cycle pulse when portout is updated.
REQ-012 dev_valid / dev_ready  output / input  1 each  write-side handshake to device.
REQ-013 dev_addr, dev_data  output  WORD_WIDTH each  head-of-queue write entry.
REQ-014 dev_rd_req  output  1; dev_rd_addr  output  WORD_WIDTH; dev_rd_valid  input  1; dev_rd_data  input  WORD_WIDTH  device read handshake.
REQ-015 halted  output  1  sticky, machine halt seen.
REQ-016 overflow, rd_err  output  1 each  sticky error flags.

Function
REQ-017 Write queue SHALL be FIFO of {portaddr, portval}; push on portset when count<DEPTH and halted=0.
REQ-018 portset with count==DEPTH SHALL drop the write and set overflow, even if a pop occurs that cycle.
REQ-019 portset while halted=1 SHALL be ignored silently (no overflow).
REQ-020 dev_valid SHALL equal (count!=0 && halted==0); dev_addr/dev_data SHALL show head entry combinationally from storage.
REQ-021 Pop SHALL occur on dev_valid && dev_ready; simultaneous push and pop (non-full) SHALL leave count unchanged.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-023 Popping an entry with address 0 SHALL set halted the next cycle; remaining entries SHALL be held, not presented.
REQ-024 Read FSM states: IDLE, DRAIN, REQ.
REQ-025 IDLE + portget: latch portaddr into rd_addr; go DRAIN if queue non-empty after this cycle's push/pop, else REQ.
REQ-026 DRAIN -> REQ when count==0; if halted becomes 1 in DRAIN, go IDLE, set rd_err, no rd_done.
REQ-027 REQ: dev_rd_req=1, dev_rd_addr=rd_addr; on dev_rd_valid, portout<=dev_rd_data, rd_done=1 next cycle, go IDLE.
REQ-028 portget while FSM not IDLE SHALL be ignored and set rd_err.
REQ-029 portset and portget in same cycle: write SHALL be queued before read, so read waits for its drain.
REQ-030 port_busy SHALL equal (count==DEPTH) || (FSM!=IDLE).
REQ-031 dev_rd_valid outside REQ SHALL be ignored.
REQ-032 Minimum read latency, empty queue: portget cycle N, dev_rd_req N+1, dev_rd_valid N+1 gives portout and rd_done at N+2.

Reset
REQ-033 reset SHALL empty queue (pointers, count 0), FSM IDLE, portout 0, rd_done 0, halted 0, overflow 0, rd_err 0.
REQ-034 reset SHALL take priority over all strobes in the same cycle; in-flight reads are abandoned with no rd_done.
REQ-035 Queue storage contents need not be reset.

Verification
REQ-036 DEPTH=4, dev_ready=0, 5 portset (addr 1..5) -> count 4, port_busy=1, overflow=1; dev_ready=1 pops addr 1,2,3,4 in order.
REQ-037 Write addr 0 val 7, dev_ready=1 -> dev_addr=0 accepted, halted=1 next cycle, later portset ignored, overflow stays 0.
REQ-038 Empty queue, portget addr 9, dev_rd_data=0x1234 returned in REQ -> portout=0x1234, rd_done one pulse, port_busy high 2 cycles.
REQ-039 Same-cycle portset (addr 3) and portget (addr 5) -> dev_rd_req stays low until addr-3 write popped, then read completes.
REQ-040 portget during REQ -> rd_err=1, first read completes normally.
REQ-041 reset asserted in REQ with queue holding 2 entries -> next cycle count 0, FSM IDLE, port_busy 0, no rd_done.
